// File: rtl/lab_reduce_unit.sv
// Purpose: synchronise and debounce WIDTH switches plus a mode button, drive registered
//          AND/OR/XOR/NOR reductions onto LEDs, a mode-selected result LED and a change counter.
// Latency: sw edge -> debounced after 2+DB_CYCLES clocks -> ld/sel_out/chg_pulse one clock later.
// Backpressure: none; free-running, every output is refreshed each cycle.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   sw[WIDTH]       raw switches (asynchronous to clk)
//   btn             raw mode-advance button (asynchronous to clk)
//   cnt_clr         synchronous clear of chg_cnt (clk domain)
//   ld[3:0]         {NOR, XOR, OR, AND} of the debounced switch vector
//   sel_out         reduction picked by mode
//   mode[1:0]       0=AND 1=OR 2=XOR 3=NOR, stepped by debounced btn rising edges
//   chg_cnt[CNT_W]  saturating count of cycles in which the debounced vector changed
//   chg_pulse       one-cycle pulse aligned with the ld update following a change
module lab_reduce_unit #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  input  logic             cnt_clr,
  output logic [3:0]       ld,
  output logic             sel_out,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             chg_pulse
);

  // btn rides along as the top bit so it shares the exact sync + debounce path.
  localparam int NB  = WIDTH + 1;
  localparam int DCW = $clog2(DB_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DB_CYCLES - 1);

  logic [NB-1:0]    r_s1;
  logic [NB-1:0]    r_s2;
  logic [NB-1:0]    r_stable;
  logic [DCW-1:0]   r_db_cnt [NB];
  logic [NB-1:0]    w_accept;

  logic [3:0]       w_red;
  logic             w_btn_rise;
  logic             w_sw_changed;

  logic [3:0]       r_ld;
  logic             r_sel;
  logic [1:0]       r_mode;
  logic             r_changed;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser for every switch bit and the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {btn, sw};
      r_s2 <= r_s1;
    end
  end

  // A bit is accepted once it has disagreed with its stable value for DB_CYCLES
  // consecutive cycles; the counter sits at DB_CYCLES-1 on the last of those cycles.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NB; i++) begin
      w_accept[i] = (r_s2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < NB; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          // Any return to agreement throws away the partial count.
          r_db_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DCW'(1);
        end
      end
    end
  end

  assign w_red        = {~|r_stable[WIDTH-1:0], ^r_stable[WIDTH-1:0],
                          |r_stable[WIDTH-1:0],  &r_stable[WIDTH-1:0]};
  // Debounced button going 0 -> 1; a held button never re-triggers.
  assign w_btn_rise   = w_accept[WIDTH] & r_s2[WIDTH];
  // Several switch bits accepted together still count as one change.
  assign w_sw_changed = |w_accept[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld      <= 4'b1000;
      r_sel     <= 1'b0;
      r_mode    <= 2'd0;
      r_changed <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ld      <= w_red;
      // Uses the pre-update mode, so sel_out lags ld[mode] one cycle after a step.
      r_sel     <= w_red[r_mode];
      if (w_btn_rise) begin
        r_mode <= r_mode + 2'd1;
      end
      // The stable vector updates on the accept edge and ld one edge later; the
      // extra stage keeps chg_pulse and the counter aligned with the new ld.
      r_changed <= w_sw_changed;
      r_pulse   <= r_changed;
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (r_changed && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ld        = r_ld;
  assign sel_out   = r_sel;
  assign mode      = r_mode;
  assign chg_cnt   = r_cnt;
  assign chg_pulse = r_pulse;

endmodule

// File: tb/tb_lab_reduce_unit.sv
// Bench for lab_reduce_unit: WIDTH=4, DB_CYCLES=4, CNT_W=2 (small counter to reach saturation).
// Reference model: sliding window over raw samples; a bit is accepted when every sample in
// the window disagrees with the model's stable value. Outputs are derived from plain reductions.
module tb_lab_reduce_unit;
  localparam int W  = 4;
  localparam int DB = 4;
  localparam int CW = 2;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic [W-1:0]  sw      = '0;
  logic          btn     = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [3:0]    ld;
  logic          sel_out;
  logic [1:0]    mode;
  logic [CW-1:0] chg_cnt;
  logic          chg_pulse;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lab_reduce_unit #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .cnt_clr(cnt_clr),
    .ld(ld), .sel_out(sel_out), .mode(mode), .chg_cnt(chg_cnt), .chg_pulse(chg_pulse)
  );

  // ---------------- reference model ----------------
  logic [W:0]    m_hist[$];
  logic [W:0]    m_st;
  logic [3:0]    m_ld;
  logic          m_sel;
  logic [1:0]    m_mode;
  logic [CW-1:0] m_cnt;
  logic          m_pulse;
  logic          m_chg_d;

  function automatic logic [3:0] red4(input logic [W-1:0] v);
    return {~|v, ^v, |v, &v};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_b
    logic [W:0] acc;
    logic [3:0] red_old;
    if (!rst_n) begin
      m_hist.delete();
      for (int k = 0; k < DB + 2; k++) m_hist.push_back('0);
      m_st = '0; m_ld = 4'b1000; m_sel = 1'b0; m_mode = 2'd0;
      m_cnt = '0; m_pulse = 1'b0; m_chg_d = 1'b0;
    end else begin
      // m_hist[DB+1] is this edge's sample; the synchroniser makes the
      // decision window the DB samples ending two edges ago: m_hist[0..DB-1].
      m_hist.push_back({btn, sw});
      void'(m_hist.pop_front());
      acc = '1;
      for (int k = 0; k < DB; k++) acc &= (m_hist[k] ^ m_st);
      red_old = red4(m_st[W-1:0]);
      m_ld    = red_old;
      m_sel   = red_old[m_mode];
      m_pulse = m_chg_d;
      if (cnt_clr) m_cnt = '0;
      else if (m_chg_d && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      m_chg_d = |acc[W-1:0];
      if (acc[W] && !m_st[W]) m_mode = m_mode + 2'd1;
      m_st = m_st ^ acc;
    end
  end

  wire [9:0] obs   = {ld, sel_out, mode, chg_cnt, chg_pulse};
  wire [9:0] exp_m = {m_ld, m_sel, m_mode, m_cnt, m_pulse};

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ld !== 4'b1000) begin n_err++; $display("FAIL reset_ld got=%b exp=1000", ld); end
    n_vec++; if (sel_out !== 1'b0) begin n_err++; $display("FAIL reset_sel got=%b exp=0", sel_out); end
    n_vec++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    n_vec++; if (chg_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", chg_cnt); end
    n_vec++; if (chg_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse got=%b exp=0", chg_pulse); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL reset_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      n_vec++; if (ld !== 4'b1000 || chg_pulse !== 1'b0) begin
        n_err++; $display("FAIL reset_idle ld=%b pulse=%b exp ld=1000 pulse=0", ld, chg_pulse); end
    end
  endtask

  task automatic test_sw_latency();
    logic [3:0] pat [2];
    logic [3:0] ld_new [2];
    logic [3:0] ld_old;
    pat[0] = 4'b1111; ld_new[0] = 4'b0011;
    pat[1] = 4'b1011; ld_new[1] = 4'b0110;
    ld_old = 4'b1000;
    for (int p = 0; p < 2; p++) begin
      sw = pat[p];
      for (int e = 1; e <= 9; e++) begin
        @(negedge clk);
        n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL latency_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
        n_vec++; if (ld !== ((e >= 7) ? ld_new[p] : ld_old)) begin
          n_err++; $display("FAIL latency_ld edge=%0d got=%b exp=%b", e, ld, (e >= 7) ? ld_new[p] : ld_old); end
        n_vec++; if (chg_pulse !== (e == 7)) begin
          n_err++; $display("FAIL latency_pulse edge=%0d got=%b exp=%b", e, chg_pulse, (e == 7)); end
      end
      n_vec++; if (chg_cnt !== CW'(p + 1)) begin n_err++; $display("FAIL latency_cnt got=%0d exp=%0d", chg_cnt, p + 1); end
      ld_old = ld_new[p];
    end
  endtask

  task automatic test_glitch();
    bit saw_hi;
    sw = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL glitch_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
    end
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    n_vec++; if (ld !== 4'b0010 || chg_cnt !== '0) begin
      n_err++; $display("FAIL glitch_setup ld=%b cnt=%0d exp ld=0010 cnt=0", ld, chg_cnt); end
    // Three-cycle high on sw[0]: must be rejected.
    for (int c = 0; c < 12; c++) begin
      sw = (c < 3) ? 4'b1011 : 4'b1010;
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL glitch3_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      n_vec++; if (ld !== 4'b0010 || chg_pulse !== 1'b0 || chg_cnt !== '0) begin
        n_err++; $display("FAIL glitch3_reject ld=%b pulse=%b cnt=%0d exp 0010/0/0", ld, chg_pulse, chg_cnt); end
    end
    // Four-cycle high: accepted, then the fall is accepted as a second change.
    saw_hi = 0;
    for (int c = 0; c < 16; c++) begin
      sw = (c < 4) ? 4'b1011 : 4'b1010;
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL glitch4_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      if (ld === 4'b0110) saw_hi = 1;
    end
    n_vec++; if (saw_hi !== 1'b1) begin n_err++; $display("FAIL glitch4_accept saw_0110=%b exp=1", saw_hi); end
    n_vec++; if (chg_cnt !== 2'd2 || ld !== 4'b0010) begin
      n_err++; $display("FAIL glitch4_end cnt=%0d ld=%b exp cnt=2 ld=0010", chg_cnt, ld); end
  endtask

  task automatic test_btn_mode();
    logic [3:0] sel_tab;
    sel_tab = 4'b0011;  // sel after presses 1..4 with sw=0001: OR=1, XOR=1, NOR=0, AND=0
    sw = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL btn_setup_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
    end
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2 * (DB + 5); c++) begin
        btn = (c < DB + 5);
        @(negedge clk);
        n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL btn_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      end
      n_vec++; if (mode !== 2'(p + 1)) begin n_err++; $display("FAIL btn_mode press=%0d got=%0d exp=%0d", p + 1, mode, 2'(p + 1)); end
      n_vec++; if (sel_out !== sel_tab[p]) begin n_err++; $display("FAIL btn_sel press=%0d got=%b exp=%b", p + 1, sel_out, sel_tab[p]); end
    end
    for (int c = 0; c < 115; c++) begin
      btn = (c < 100);
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL btn_hold_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
    end
    n_vec++; if (mode !== 2'd1) begin n_err++; $display("FAIL btn_hold_once got=%0d exp=1", mode); end
  endtask

  task automatic test_cnt_saturate();
    bit got;
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sw = sw ^ 4'b0100;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL sat_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      end
      n_vec++; if (chg_cnt !== ((i < 3) ? CW'(i + 1) : 2'd3)) begin
        n_err++; $display("FAIL sat_cnt change=%0d got=%0d exp=%0d", i + 1, chg_cnt, (i < 3) ? i + 1 : 3); end
    end
    // Clear in the very cycle the change would be counted.
    sw = sw ^ 4'b0100;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL clr_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      if (m_chg_d) got = 1;
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL clr_wait change not seen within 20 cycles, exp seen"); end
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    n_vec++; if (chg_cnt !== '0 || chg_pulse !== 1'b1) begin
      n_err++; $display("FAIL clr_priority cnt=%0d pulse=%b exp cnt=0 pulse=1", chg_cnt, chg_pulse); end
  endtask

  task automatic test_reset_mid();
    sw = 4'b0000;
    for (int c = 0; c < 10; c++) @(negedge clk);
    sw = 4'b1111;
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({ld, sel_out, mode, chg_cnt, chg_pulse} !== {4'b1000, 1'b0, 2'd0, 2'd0, 1'b0}) begin
      n_err++; $display("FAIL midrst_values got=%b exp=1000_0_00_00_0", obs); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL midrst_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
      n_vec++; if (ld !== ((e >= 3 + DB) ? 4'b0011 : 4'b1000)) begin
        n_err++; $display("FAIL midrst_ld edge=%0d got=%b exp=%b", e, ld, (e >= 3 + DB) ? 4'b0011 : 4'b1000); end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        sw   = W'($urandom);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 6) == 0) btn = ~btn;
      cnt_clr = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      n_vec++; if (obs !== exp_m) begin n_err++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, obs, exp_m); end
    end
    cnt_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw_latency();
    test_glitch();
    test_btn_mode();
    test_cnt_saturate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lab_reduce_unit.md
Name: lab_reduce_unit

Overview:
- Parametrised, clocked successor to the 4-switch reduction lab block.
- Synchronises and debounces WIDTH switch inputs, then computes the AND/OR/XOR/NOR reductions of the stable vector into registered LED outputs.
- Adds a button-stepped mode selector driving a single result LED, and a saturating counter of debounced input changes.
- Sits directly between board switches/button and LEDs in the lab top level.

Parameters:
- WIDTH, 4, number of switch inputs (>=1).
- DB_CYCLES, 16, consecutive cycles a synchronised input must differ from its stable value before it is accepted (>=1).
- CNT_W, 8, width of the change counter (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  WIDTH  raw switch inputs, asynchronous to clk.
- btn  input  1  raw mode-advance button, asynchronous to clk.
- cnt_clr  input  1  synchronous clear of chg_cnt, already in the clk domain.
- ld  output  4  registered reductions of the debounced vector: ld[0]=AND, ld[1]=OR, ld[2]=XOR, ld[3]=NOR.
- sel_out  output  1  registered reduction selected by mode.
- mode  output  2  current mode: 0=AND, 1=OR, 2=XOR, 3=NOR.
- chg_cnt  output  CNT_W  saturating count of cycles in which the debounced vector changed.
- chg_pulse  output  1  one-cycle pulse aligned with the ld update that follows a change.

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, stable vector and debounce counters go to 0; mode=0; ld=4'b1000; sel_out=0; chg_cnt=0; chg_pulse=0. Reset mid-debounce discards any partial count.
- Synchroniser: each sw bit and btn passes through 2 flops (s1, s2).
- Debounce, per bit, one counter of $clog2(DB_CYCLES+1) bits:
  - s2==stable: counter resets to 0.
  - s2!=stable and counter==DB_CYCLES-1: stable<=s2, counter<=0.
  - Otherwise the counter increments.
  - Any return to equality before acceptance resets the counter, so glitches shorter than DB_CYCLES are rejected.
- Latency: a clean sw change reaches stable after 2+DB_CYCLES rising edges, and reaches ld one edge later (3+DB_CYCLES total).
- ld: registered each cycle from the current stable vector (&, |, ^, ~|).
- sel_out: registered each cycle from the reduction chosen by the current mode, so it equals ld[mode] except in the single cycle after a mode change.
- btn uses the identical sync+debounce path. Each rising edge of the debounced btn advances mode 0->1->2->3->0, wrapping at 3. A held btn advances mode once only.
- Change detection: changed = any stable bit updating this cycle.
  - Several bits updating in the same cycle count once.
  - chg_pulse registers changed, so it is high for exactly one cycle, coincident with the new ld value.
- chg_cnt, evaluated in this priority order:
  - cnt_clr=1: chg_cnt<=0, and any simultaneous change is lost.
  - changed=1 and chg_cnt not all-ones: increment.
  - At all-ones: hold (saturate, no wrap).
- btn and sw are independent; a mode step and a sw change in the same cycle both take effect.

Test Plan:
- Reset -> ld=4'b1000, sel_out=0, mode=0, chg_cnt=0, chg_pulse=0. Release reset with sw=4'b0000 -> outputs unchanged.
- WIDTH=4, DB_CYCLES=4: sw 0000->1111 at edge 0 -> ld=4'b0011 exactly at edge 7; chg_pulse high only at edge 7; chg_cnt=1. Then sw=1011 -> ld=4'b0110 after 7 edges; chg_cnt=2.
- sw[0] glitch high for 3 cycles (DB_CYCLES=4) -> ld, chg_cnt and chg_pulse unchanged. Repeat with a 4-cycle pulse -> accepted, ld=4'b0110.
- With sw=0001, four clean btn presses -> mode steps 1,2,3,0. sel_out follows 1,1,0,0 one cycle after each mode change. A 100-cycle hold counts as one press.
- CNT_W=2: five accepted changes -> chg_cnt 1,2,3,3,3. Assert cnt_clr in the same cycle as a change -> chg_cnt=0.
- Assert rst_n low 2 cycles into a debounce of sw=1111 -> immediate reset values. After release with sw held, ld=4'b0011 after 3+DB_CYCLES edges.
